// File: rtl/lsu_split_access.sv
// Sequential load/store unit driving a req/gnt/rvalid data port. Optionally splits
// word-crossing accesses into two aligned transactions and merges the load data.
module lsu_split_access #(
  parameter int MISALIGN_SPLIT = 1,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault_misalign,
  output logic              fault_access,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_mask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam logic              SPLIT_EN  = (MISALIGN_SPLIT != 0);
  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_store, r_split, r_done;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr2;
  logic [3:0]        r_mask_hi;
  logic [31:0]       r_wdata_hi, r_rd_lo, r_rdata;
  logic              r_fault_misalign, r_fault_access;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_mask;
  logic [31:0]       r_mem_wdata;

  logic [1:0]        w_off;
  logic [2:0]        w_size;
  logic [3:0]        w_smask;
  logic              w_illegal, w_cross, w_fault;
  logic [7:0]        w_mask8;
  logic [63:0]       w_wd64, w_rd64;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_raw, w_ext;

  // Decode the incoming op: size, crossing, fault and the two-word lane layout
  always_comb begin
    w_off     = addr[1:0];
    w_illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    case (funct3[1:0])
      2'b00:   begin w_size = 3'd1; w_smask = 4'b0001; end
      2'b01:   begin w_size = 3'd2; w_smask = 4'b0011; end
      default: begin w_size = 3'd4; w_smask = 4'b1111; end
    endcase
    w_cross     = (({1'b0, w_off} + w_size) > 3'd4);
    w_fault     = w_illegal || (w_cross && !SPLIT_EN);
    w_mask8     = {4'b0000, w_smask} << w_off;
    w_wd64      = {32'h0000_0000, wdata} << {w_off, 3'b000};
    w_word_addr = {addr[ADDR_W-1:2], 2'b00};
  end

  // Merge returned words, shift the addressed bytes down and extend them
  always_comb begin
    if (r_state == S_WAIT2) begin
      w_rd64 = {mem_rdata, r_rd_lo};
    end else begin
      w_rd64 = {32'h0000_0000, mem_rdata};
    end
    w_raw = 32'(w_rd64 >> {r_off, 3'b000});
    case (r_f3)
      3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_ext = {24'h00_0000, w_raw[7:0]};
      3'b101:  w_ext = {16'h0000, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stray gnt/rvalid outside their states are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_state_nxt = w_fault ? S_FIN : S_REQ1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ1: begin
        if (mem_gnt) w_state_nxt = S_WAIT1;
        else         w_state_nxt = S_REQ1;
      end
      S_WAIT1: begin
        if (mem_rvalid) w_state_nxt = (r_split && !mem_err) ? S_REQ2 : S_FIN;
        else            w_state_nxt = S_WAIT1;
      end
      S_REQ2: begin
        if (mem_gnt) w_state_nxt = S_WAIT2;
        else         w_state_nxt = S_REQ2;
      end
      S_WAIT2: begin
        if (mem_rvalid) w_state_nxt = S_FIN;
        else            w_state_nxt = S_WAIT2;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Op capture, registered memory request and registered completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store          <= 1'b0;
      r_split          <= 1'b0;
      r_done           <= 1'b0;
      r_f3             <= 3'b000;
      r_off            <= 2'b00;
      r_addr2          <= {ADDR_W{1'b0}};
      r_mask_hi        <= 4'b0000;
      r_wdata_hi       <= 32'h0000_0000;
      r_rd_lo          <= 32'h0000_0000;
      r_rdata          <= 32'h0000_0000;
      r_fault_misalign <= 1'b0;
      r_fault_access   <= 1'b0;
      r_mem_req        <= 1'b0;
      r_mem_we         <= 1'b0;
      r_mem_addr       <= {ADDR_W{1'b0}};
      r_mem_mask       <= 4'b0000;
      r_mem_wdata      <= 32'h0000_0000;
    end else begin
      r_done <= (w_state_nxt == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_store          <= op_store;
            r_f3             <= funct3;
            r_off            <= w_off;
            r_split          <= w_cross;
            r_addr2          <= w_word_addr + WORD_STEP;
            r_mask_hi        <= w_mask8[7:4];
            r_wdata_hi       <= w_wd64[63:32];
            r_mem_req        <= !w_fault;
            r_mem_we         <= op_store && !w_fault;
            r_mem_addr       <= w_fault ? {ADDR_W{1'b0}} : w_word_addr;
            r_mem_mask       <= w_fault ? 4'b0000 : w_mask8[3:0];
            r_mem_wdata      <= w_fault ? 32'h0000_0000 : w_wd64[31:0];
            r_fault_misalign <= w_fault;
            r_fault_access   <= 1'b0;
            r_rdata          <= 32'h0000_0000;
          end
        end
        S_REQ1, S_REQ2: begin
          if (mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_mask  <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
          end
        end
        S_WAIT1: begin
          if (mem_rvalid) begin
            r_rd_lo <= mem_rdata;
            if (r_split && !mem_err) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= r_store;
              r_mem_addr  <= r_addr2;
              r_mem_mask  <= r_mask_hi;
              r_mem_wdata <= r_wdata_hi;
            end else begin
              r_fault_access <= mem_err;
              r_rdata        <= (mem_err || r_store) ? 32'h0000_0000 : w_ext;
            end
          end
        end
        S_WAIT2: begin
          if (mem_rvalid) begin
            r_fault_access <= mem_err;
            r_rdata        <= (mem_err || r_store) ? 32'h0000_0000 : w_ext;
          end
        end
        S_FIN: begin
          r_fault_misalign <= 1'b0;
          r_fault_access   <= 1'b0;
          r_rdata          <= 32'h0000_0000;
        end
        default: ;
      endcase
    end
  end

  assign stall          = op_valid && !r_done;
  assign done           = r_done;
  assign rdata          = r_rdata;
  assign fault_misalign = r_fault_misalign;
  assign fault_access   = r_fault_access;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_mask       = r_mem_mask;
  assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: a memory responder checks requests against a
// scoreboard of expected transactions and results; a second instance has splitting off.
module tb_lsu_split_access;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_valid0, op_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  logic        stall, done, fault_misalign, fault_access, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  logic        stall0, done0, fault_misalign0, fault_access0, mem_req0, mem_we0;
  logic [31:0] rdata0, mem_addr0, mem_wdata0;
  logic [3:0]  mem_mask0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fm;
    logic        fa;
    logic [31:0] lat;
  } res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lsu_split_access #(.MISALIGN_SPLIT(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .fault_misalign(fault_misalign), .fault_access(fault_access),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  lsu_split_access #(.MISALIGN_SPLIT(0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .op_valid(op_valid0), .op_store(op_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall0), .done(done0), .rdata(rdata0),
    .fault_misalign(fault_misalign0), .fault_access(fault_access0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_mask(mem_mask0),
    .mem_wdata(mem_wdata0), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] m,
                          input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.mask = m; r.wdata = wd;
    exp_req.push_back(r);
  endtask

  task automatic push_res(input logic [31:0] rd, input logic fm, input logic fa,
                          input logic [31:0] lat);
    res_t r;
    r.rdata = rd; r.fm = fm; r.fa = fa; r.lat = lat;
    exp_res.push_back(r);
  endtask

  task automatic idle_mem();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
  endtask

  // Drive one op on u_dut and act as the memory; gw/rw are gnt/rvalid wait cycles.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] w1, input logic [31:0] w2,
                       input int gw, input int rw, input logic e1);
    req_t cur;
    res_t er;
    logic pend = 1'b0;
    logic fin  = 1'b0;
    int   wc = 0, rc = -1, nresp = 0;
    @(negedge clk);
    op_valid = 1'b1; op_store = st; funct3 = f3; addr = a; wdata = wd;
    #1 chk("stall_accept", 32'(stall), 32'd1);
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      idle_mem();
      if (done) begin
        fin = 1'b1;
        chk("result_expected", 32'(exp_res.size() > 0), 32'd1);
        if (exp_res.size() > 0) begin
          er = exp_res.pop_front();
          chk("rdata", rdata, er.rdata);
          chk("fault_misalign", 32'(fault_misalign), 32'(er.fm));
          chk("fault_access", 32'(fault_access), 32'(er.fa));
          chk("latency", 32'(c), er.lat);
        end
        chk("stall_at_done", 32'(stall), 32'd0);
        chk("reqs_left", 32'(exp_req.size()), 32'd0);
        op_valid = 1'b0;
      end else begin
        chk("stall_busy", 32'(stall), 32'd1);
        if (mem_req) begin
          if (!pend) begin
            chk("req_expected", 32'(exp_req.size() > 0), 32'd1);
            if (exp_req.size() > 0) begin
              cur = exp_req.pop_front();
              chk("mem_addr", mem_addr, cur.addr);
              chk("mem_we", 32'(mem_we), 32'(cur.we));
              chk("mem_mask", 32'(mem_mask), 32'(cur.mask));
              chk("mem_wdata", mem_wdata, cur.wdata);
              pend = 1'b1;
              wc   = 0;
            end
          end else begin
            chk("hold_addr", mem_addr, cur.addr);
            chk("hold_mask", 32'(mem_mask), 32'(cur.mask));
            chk("hold_wdata", mem_wdata, cur.wdata);
            chk("hold_we", 32'(mem_we), 32'(cur.we));
          end
          if (pend) begin
            if (wc == gw) begin
              mem_gnt = 1'b1; pend = 1'b0; rc = 0;
            end else begin
              wc++;
            end
          end
        end else if (pend) begin
          chk("req_retracted", 32'(mem_req), 32'd1);
          pend = 1'b0;
        end else if (rc >= 0) begin
          if (rc == rw) begin
            mem_rvalid = 1'b1;
            mem_err    = (nresp == 0) ? e1 : 1'b0;
            mem_rdata  = (nresp == 0) ? w1 : w2;
            nresp++;
            rc = -1;
          end else begin
            rc++;
          end
        end
      end
    end
    chk("done_seen", 32'(fin), 32'd1);
    op_valid = 1'b0;
    @(negedge clk);
    idle_mem();
    chk("done_pulse", 32'(done), 32'd0);
    chk("fault_pulse", {30'd0, fault_misalign, fault_access}, 32'd0);
    chk("req_idle", 32'(mem_req), 32'd0);
  endtask

  // Faulting op on the non-splitting instance: done must follow acceptance directly.
  task automatic do_fault0(input logic [2:0] f3, input logic [31:0] a);
    res_t er;
    push_res(32'h0, 1'b1, 1'b0, 32'd1);
    @(negedge clk);
    op_valid0 = 1'b1; op_store = 1'b0; funct3 = f3; addr = a; wdata = 32'h5555_AAAA;
    #1 chk("d0_stall_accept", 32'(stall0), 32'd1);
    @(negedge clk);
    er = exp_res.pop_front();
    chk("d0_done_lat1", 32'(done0), 32'(er.lat == 32'd1));
    chk("d0_fault_misalign", 32'(fault_misalign0), 32'(er.fm));
    chk("d0_fault_access", 32'(fault_access0), 32'(er.fa));
    chk("d0_rdata", rdata0, er.rdata);
    chk("d0_no_req", 32'(mem_req0), 32'd0);
    op_valid0 = 1'b0;
    @(negedge clk);
    chk("d0_done_pulse", 32'(done0), 32'd0);
    chk("d0_req_idle", 32'(mem_req0), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {25'd0, mem_req, mem_we, done, stall, fault_misalign, fault_access,
        |rdata}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_mask"}, 32'(mem_mask), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_valid0 = 1'b0; op_store = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    idle_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_d0", {27'd0, mem_req0, done0, stall0, fault_misalign0, fault_access0}, 32'd0);
    rst = 1'b0;

    // Aligned LW
    push_req(32'h100, 1'b0, 4'b1111, 32'h0);
    push_res(32'hDEAD_BEEF, 1'b0, 1'b0, 32'd3);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);

    // LB / LBU at offset 3
    push_req(32'h100, 1'b0, 4'b1000, 32'h0);
    push_res(32'hFFFF_FF80, 1'b0, 1'b0, 32'd3);
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0, 0, 1'b0);
    push_req(32'h100, 1'b0, 4'b1000, 32'h0);
    push_res(32'h0000_0080, 1'b0, 1'b0, 32'd3);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0, 0, 1'b0);

    // LH at offset 1 stays in one word (mask 0110), sign extended
    push_req(32'h100, 1'b0, 4'b0110, 32'h0);
    push_res(32'hFFFF_F00F, 1'b0, 1'b0, 32'd3);
    do_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h12F0_0F34, 32'h0, 0, 0, 1'b0);

    // SH and SB stores; ack data must not leak into rdata
    push_req(32'h100, 1'b1, 4'b1100, 32'h1234_0000);
    push_res(32'h0, 1'b0, 1'b0, 32'd3);
    do_op(1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0, 0, 0, 1'b0);
    push_req(32'h0, 1'b1, 4'b0010, 32'h2233_4400);
    push_res(32'h0, 1'b0, 1'b0, 32'd3);
    do_op(1'b1, 3'b000, 32'h1, 32'h1122_3344, 32'hFFFF_FFFF, 32'h0, 0, 0, 1'b0);

    // Split SW across 0x200
    push_req(32'h1FC, 1'b1, 4'b1100, 32'hCCDD_0000);
    push_req(32'h200, 1'b1, 4'b0011, 32'h0000_AABB);
    push_res(32'h0, 1'b0, 1'b0, 32'd5);
    do_op(1'b1, 3'b010, 32'h1FE, 32'hAABB_CCDD, 32'h0, 32'h0, 0, 0, 1'b0);

    // Split LH at 0x3, zero-wait then with gnt/rvalid wait states
    push_req(32'h0, 1'b0, 4'b1000, 32'h0);
    push_req(32'h4, 1'b0, 4'b0001, 32'h0);
    push_res(32'h0000_2211, 1'b0, 1'b0, 32'd5);
    do_op(1'b0, 3'b001, 32'h3, 32'h0, 32'h11AA_BBCC, 32'h3344_5522, 0, 0, 1'b0);
    push_req(32'h0, 1'b0, 4'b1000, 32'h0);
    push_req(32'h4, 1'b0, 4'b0001, 32'h0);
    push_res(32'h0000_2211, 1'b0, 1'b0, 32'd15);
    do_op(1'b0, 3'b001, 32'h3, 32'h0, 32'h11AA_BBCC, 32'h3344_5522, 3, 2, 1'b0);

    // Split LW whose second word wraps to address 0
    push_req(32'hFFFF_FFFC, 1'b0, 4'b1110, 32'h0);
    push_req(32'h0, 1'b0, 4'b0001, 32'h0);
    push_res(32'h99DD_CCBB, 1'b0, 1'b0, 32'd5);
    do_op(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 32'hDDCC_BBAA, 32'h0000_0099, 0, 0, 1'b0);

    // Error on first half of a split load: no second request
    push_req(32'h104, 1'b0, 4'b1100, 32'h0);
    push_res(32'h0, 1'b0, 1'b1, 32'd3);
    do_op(1'b0, 3'b010, 32'h106, 32'h0, 32'h1234_5678, 32'h0, 0, 0, 1'b1);

    // Illegal funct3 codes fault immediately without a memory access
    push_res(32'h0, 1'b1, 1'b0, 32'd1);
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    push_res(32'h0, 1'b1, 1'b0, 32'd1);
    do_op(1'b1, 3'b110, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);

    // Splitting disabled
    do_fault0(3'b010, 32'h2);
    do_fault0(3'b011, 32'h0);

    // Reset while waiting for rvalid
    @(negedge clk);
    op_valid = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h106; wdata = 32'h0;
    @(negedge clk);
    chk("rst_wait_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_wait1");

    // Reset while a request is pending drops mem_req
    @(negedge clk);
    op_valid = 1'b1; op_store = 1'b1; funct3 = 3'b010; addr = 32'h200; wdata = 32'h1;
    @(negedge clk);
    chk("rst_req1_req", 32'(mem_req), 32'd1);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_req1");

    // Unit resumes normally after reset
    push_req(32'h100, 1'b0, 4'b1111, 32'h0);
    push_res(32'hCAFE_F00D, 1'b0, 1'b0, 32'd3);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);

    chk("scoreboard_empty", 32'(exp_req.size() + exp_res.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_split_access.md
Name: lsu_split_access

Overview:
Sequential load/store unit between the Memory stage and a req/gnt/rvalid data-memory port with variable latency. It issues byte, halfword and word accesses and stalls the pipeline while an access is outstanding. It sign- or zero-extends load data. Optionally, it splits a misaligned access that crosses a 32-bit word boundary into two aligned transactions; the earlier single-cycle combinational unit could not do this.

Parameters:
MISALIGN_SPLIT, 1, 1 = split word-crossing accesses into two transactions; 0 = raise a misaligned fault with no memory access
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  M-stage holds a load or store; the op is held stable while stall is high
op_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I size/sign code
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  freeze pipeline
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, valid when done is high
fault_misalign  out  1  pulse with done: misaligned and MISALIGN_SPLIT=0, or illegal funct3
fault_access  out  1  pulse with done: memory reported an error
mem_req  out  1  request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
mem_mask  out  4  byte enables
mem_wdata  out  32  lane-aligned write data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  load data / store ack valid
mem_rdata  in  32  read data
mem_err  in  1  error, qualified by mem_rvalid

Behaviour:
- Clock and reset: one clock domain. rst is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0. Reset asserted mid-transaction drops mem_req on the next edge and discards the transaction.
- States and transitions:
  - IDLE: op_valid accepts the op and latches addr, funct3, op_store and wdata. Next state is REQ1, or FIN when the op faults.
  - REQ1: mem_req is high. On mem_gnt, go to WAIT1.
  - WAIT1: on mem_rvalid, capture data. Go to REQ2 if split and no mem_err, else FIN.
  - REQ2: mem_req is high. On mem_gnt, go to WAIT2.
  - WAIT2: on mem_rvalid, capture data and go to FIN.
  - FIN: done=1, rdata and faults are valid. Next state is IDLE.
- Stores also wait for mem_rvalid, which acts as the write acknowledge.
- Request rules:
  - mem_req, mem_addr, mem_we, mem_mask and mem_wdata stay stable from request until mem_gnt is sampled high. mem_req is never retracted before grant.
  - mem_req is deasserted in the cycle after grant.
  - mem_gnt and mem_rvalid outside their expected states are ignored.
- stall = op_valid and not done. A new op is accepted only in IDLE, so back-to-back ops are separated by the FIN cycle.
- Sizes and offsets: off = addr[1:0]. Sizes are byte (funct3 000/100), half (001/101) and word (010). funct3 011, 110 and 111 are illegal: they go straight to FIN with fault_misalign and issue no memory access.
- Crossing rule: an access crosses a word boundary when off + size_bytes > 4. A halfword at off=1 does not cross and uses mask 0110.
- Non-crossing access: mem_mask = ((1<<size)-1) << off. mem_wdata = wdata << 8*off.
- Crossing access with MISALIGN_SPLIT=1:
  - First access: word of addr, mask = bytes off..3.
  - Second access: word of addr+4, mask = remaining low bytes.
  - Store data: 64-bit value wdata << 8*off. The low 32 bits go to the first access, the high 32 bits to the second.
  - Load data: {second_rdata, first_rdata} >> 8*off, low size bytes kept.
  - Second-word address increments modulo 2^ADDR_W.
- Crossing access with MISALIGN_SPLIT=0: fault_misalign is raised, with no access.
- Load extension: sign extension for 000 and 001, zero extension for 100 and 101. rdata=0 when done is accompanied by any fault, and for stores.
- mem_err on the first access aborts the second access and raises fault_access. A store with fault_access leaves memory state undefined beyond the first access.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid in the next cycle): done asserts 3 cycles after acceptance for a non-split op, 5 cycles for a split op, and 1 cycle for a faulting op.

Test Plan:
- Aligned LW at 0x100, mem_rdata=0xDEADBEEF, gnt and rvalid immediate: mem_addr=0x100, mask=1111, done at accept+3, rdata=0xDEADBEEF, stall high for 3 cycles.
- LB at 0x103 with rdata=0x80XXXXXX gives rdata=0xFFFFFF80. LBU on the same data gives 0x00000080. SH at 0x102 with wdata=0x1234 gives mask=1100, mem_wdata=0x12340000.
- Split SW at 0x1FE, wdata=0xAABBCCDD: first access 0x1FC mask=1100 wdata=0xCCDD0000; second access 0x200 mask=0011 wdata=0x0000AABB; done at accept+5.
- Split LH at 0x3 with words 0x11XXXXXX and 0xXXXXXX22: rdata=0x00002211. Repeat with 3 gnt wait cycles and 2 rvalid wait cycles: outputs held stable and done delayed accordingly.
- MISALIGN_SPLIT=0 with LW at 0x2: no mem_req, fault_misalign=1 with done at accept+1. funct3=011 gives the same response.
- mem_err on the first access of a split load: no second request, fault_access=1, rdata=0. Assert rst while in WAIT1: next cycle state=IDLE with all outputs 0.
